// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared definitions for the CPU memory responder: memory-mapped
//               peripheral addresses, CMP reset value and boot/run FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int          c_DATA_W      = 19;

    // Peripheral register addresses (word addresses on the CPU data port)
    localparam logic [18:0] c_ADDR_TIMER  = 19'h40000;
    localparam logic [18:0] c_ADDR_CMP    = 19'h40001;
    localparam logic [18:0] c_ADDR_STATUS = 19'h40002;
    localparam logic [18:0] c_ADDR_LED    = 19'h40003;

    // CMP resets to the all-ones timer value
    localparam logic [18:0] c_CMP_RESET   = 19'h7FFFF;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : cpu_mem_pkg
`default_nettype wire

// File: rtl/mem_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_timer
// Description : Free-running TIMER, compare register CMP and sticky STATUS
//               bit 0 (timer match interrupt).
// Ports       : clk          - clock
//               reset        - synchronous active-low reset
//               i_run        - high while the CPU is running (TIMER counts)
//               i_we         - qualified CPU write strobe
//               i_sel_timer  - write targets TIMER
//               i_sel_cmp    - write targets CMP
//               i_sel_status - write targets STATUS
//               i_wdata      - CPU write data
//               o_timer      - current TIMER value
//               o_cmp        - current CMP value
//               o_irq        - STATUS bit 0
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timer
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run,
    input  logic        i_we,
    input  logic        i_sel_timer,
    input  logic        i_sel_cmp,
    input  logic        i_sel_status,
    input  logic [18:0] i_wdata,
    output logic [18:0] o_timer,
    output logic [18:0] o_cmp,
    output logic        o_irq
);

    logic [18:0] r_timer;
    logic [18:0] r_cmp;
    logic        r_irq;

    logic        w_match_set;
    logic        w_status_clr;

    assign w_match_set  = i_run && (r_timer == r_cmp);
    assign w_status_clr = i_we && i_sel_status && i_wdata[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timer <= '0;
            r_cmp   <= c_CMP_RESET;
            r_irq   <= 1'b0;
        end else begin
            // A CPU write replaces the increment for that cycle
            if (i_we && i_sel_timer) begin
                r_timer <= i_wdata;
            end else if (i_run) begin
                r_timer <= r_timer + 19'd1;
            end

            if (i_we && i_sel_cmp) begin
                r_cmp <= i_wdata;
            end

            // Set has priority over a simultaneous clear so no match is lost
            if (w_match_set) begin
                r_irq <= 1'b1;
            end else if (w_status_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign o_timer = r_timer;
    assign o_cmp   = r_cmp;
    assign o_irq   = r_irq;

endmodule : mem_timer
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : Memory system for a 19-bit CPU: loader-filled instruction
//               memory, data memory, TIMER/CMP/STATUS and LED registers, and
//               a boot/run FSM holding the CPU in reset until loading ends.
// Ports       : clk, reset (sync active-low)
//               pc / instr                       - instruction fetch port
//               memwrite, aluresult, writedata,
//               readdata                         - CPU data port
//               load_valid, load_ready, load_addr,
//               load_data, load_done             - boot loader port
//               cpu_hold                         - CPU reset hold
//               led, timer_irq                   - LED register, STATUS[0]
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] pc,
    output logic [18:0] instr,
    input  logic        memwrite,
    input  logic [18:0] aluresult,
    input  logic [18:0] writedata,
    output logic [18:0] readdata,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_addr,
    input  logic [18:0] load_data,
    input  logic        load_done,
    output logic        cpu_hold,
    output logic [7:0]  led,
    output logic        timer_irq
);

    localparam int          c_IMEM_AW    = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int          c_DMEM_AW    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [19:0] c_IMEM_LIMIT = 20'(IMEM_DEPTH);
    localparam logic [19:0] c_DMEM_LIMIT = 20'(DMEM_DEPTH);

    // ------------------------------------------------------------------
    // Boot / run FSM with registered outputs
    // ------------------------------------------------------------------
    state_t r_state;
    logic   r_cpu_hold;
    logic   r_load_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_BOOT;
            r_cpu_hold   <= 1'b1;
            r_load_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (load_done) begin
                        r_state      <= ST_RUN;
                        r_cpu_hold   <= 1'b0;
                        r_load_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Only reset leaves RUN
                    r_state      <= ST_RUN;
                    r_cpu_hold   <= 1'b0;
                    r_load_ready <= 1'b0;
                end
                default: begin
                    r_state      <= ST_BOOT;
                    r_cpu_hold   <= 1'b1;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_hold   = r_cpu_hold;
    assign load_ready = r_load_ready;

    // ------------------------------------------------------------------
    // Instruction memory: written by the loader in BOOT, read by fetch
    // ------------------------------------------------------------------
    logic [18:0]          r_imem [IMEM_DEPTH];
    logic [c_IMEM_AW-1:0] w_load_idx;
    logic                 w_load_hit;
    logic [c_IMEM_AW-1:0] w_fetch_idx;
    logic                 w_fetch_hit;

    assign w_load_idx  = c_IMEM_AW'(load_addr);
    assign w_load_hit  = ({12'b0, load_addr} < c_IMEM_LIMIT);
    assign w_fetch_idx = pc[c_IMEM_AW-1:0];
    assign w_fetch_hit = ({1'b0, pc} < c_IMEM_LIMIT);

    // No reset: memory contents survive a reset
    always_ff @(posedge clk) begin
        if (r_load_ready && load_valid && w_load_hit) begin
            r_imem[w_load_idx] <= load_data;
        end
    end

    assign instr = w_fetch_hit ? r_imem[w_fetch_idx] : '0;

    // ------------------------------------------------------------------
    // Data port address decode
    // ------------------------------------------------------------------
    logic                 w_we;
    logic                 w_sel_dmem;
    logic                 w_sel_timer;
    logic                 w_sel_cmp;
    logic                 w_sel_status;
    logic                 w_sel_led;
    logic [c_DMEM_AW-1:0] w_dmem_idx;

    // CPU writes are ignored while the CPU is held
    assign w_we         = memwrite && !r_cpu_hold;
    assign w_sel_dmem   = ({1'b0, aluresult} < c_DMEM_LIMIT);
    assign w_sel_timer  = (aluresult == c_ADDR_TIMER);
    assign w_sel_cmp    = (aluresult == c_ADDR_CMP);
    assign w_sel_status = (aluresult == c_ADDR_STATUS);
    assign w_sel_led    = (aluresult == c_ADDR_LED);
    assign w_dmem_idx   = aluresult[c_DMEM_AW-1:0];

    // ------------------------------------------------------------------
    // Data memory
    // ------------------------------------------------------------------
    logic [18:0] r_dmem [DMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (w_we && w_sel_dmem) begin
            r_dmem[w_dmem_idx] <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [7:0] r_led;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_led <= '0;
        end else if (w_we && w_sel_led) begin
            r_led <= writedata[7:0];
        end
    end

    assign led = r_led;

    // ------------------------------------------------------------------
    // TIMER / CMP / STATUS
    // ------------------------------------------------------------------
    logic [18:0] w_timer;
    logic [18:0] w_cmp;
    logic        w_irq;

    mem_timer u_mem_timer (
        .clk          (clk),
        .reset        (reset),
        .i_run        (r_state == ST_RUN),
        .i_we         (w_we),
        .i_sel_timer  (w_sel_timer),
        .i_sel_cmp    (w_sel_cmp),
        .i_sel_status (w_sel_status),
        .i_wdata      (writedata),
        .o_timer      (w_timer),
        .o_cmp        (w_cmp),
        .o_irq        (w_irq)
    );

    assign timer_irq = w_irq;

    // ------------------------------------------------------------------
    // Read data mux; unmapped addresses read as zero
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        if (w_sel_dmem) begin
            readdata = r_dmem[w_dmem_idx];
        end else if (w_sel_timer) begin
            readdata = w_timer;
        end else if (w_sel_cmp) begin
            readdata = w_cmp;
        end else if (w_sel_status) begin
            readdata = {18'b0, w_irq};
        end else if (w_sel_led) begin
            readdata = {11'b0, r_led};
        end
    end

endmodule : cpu_mem_responder
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Directed self-checking bench for cpu_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    logic        clk;
    logic        reset;
    logic [18:0] pc;
    logic [18:0] instr;
    logic        memwrite;
    logic [18:0] aluresult;
    logic [18:0] writedata;
    logic [18:0] readdata;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_addr;
    logic [18:0] load_data;
    logic        load_done;
    logic        cpu_hold;
    logic [7:0]  led;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_mem_responder #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .memwrite   (memwrite),
        .aluresult  (aluresult),
        .writedata  (writedata),
        .readdata   (readdata),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .cpu_hold   (cpu_hold),
        .led        (led),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%05h expected 0x%05h", tag, obs, exp);
        end
    endtask

    // One CPU store cycle, strobe dropped afterwards
    task automatic cpu_write(input logic [18:0] addr, input logic [18:0] data);
        memwrite  = 1'b1;
        aluresult = addr;
        writedata = data;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [18:0] addr, input logic [18:0] exp);
        aluresult = addr;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b0;
        pc         = '0;
        memwrite   = 1'b0;
        aluresult  = '0;
        writedata  = '0;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cpu_hold",   19'(cpu_hold),   19'h1);
        check("rst_load_ready", 19'(load_ready), 19'h1);
        check("rst_timer_irq",  19'(timer_irq),  19'h0);
        check("rst_led",        19'(led),        19'h0);
        cpu_read("rst_timer", 19'h40000, 19'h00000);
        cpu_read("rst_cmp",   19'h40001, 19'h7FFFF);

        // ---------------- boot load ----------------
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_addr  = 8'(i);
            load_data  = 19'((i + 1) * 19'h11);
            load_done  = (i == 3);
            if (i == 3) begin
                check("boot_hold_before_done", 19'(cpu_hold), 19'h1);
                cpu_read("boot_timer_holds", 19'h40000, 19'h00000);
            end
            tick();
        end
        load_valid = 1'b0;
        load_done  = 1'b0;
        check("run_cpu_hold",   19'(cpu_hold),   19'h0);
        check("run_load_ready", 19'(load_ready), 19'h0);
        pc = 19'd2;
        #1;
        check("instr_pc2", instr, 19'h00033);
        pc = 19'd3;
        #1;
        check("instr_pc3_done_cycle", instr, 19'h00044);
        pc = 19'h00100;
        #1;
        check("instr_out_of_range", instr, 19'h00000);

        // ---------------- DMEM store/load in RUN ----------------
        cpu_write(19'h00010, 19'h5A5A5);
        cpu_read("dmem_store", 19'h00010, 19'h5A5A5);
        cpu_write(19'h7FFFF, 19'h12345);
        cpu_read("unmapped_read", 19'h7FFFF, 19'h00000);
        cpu_read("dmem_after_unmapped", 19'h00010, 19'h5A5A5);

        // ---------------- TIMER wrap ----------------
        cpu_write(19'h40000, 19'h7FFFE);
        cpu_read("timer_written", 19'h40000, 19'h7FFFE);
        tick();
        cpu_read("timer_max", 19'h40000, 19'h7FFFF);
        tick();
        cpu_read("timer_wrap", 19'h40000, 19'h00000);
        // TIMER equalled the reset CMP value 0x7FFFF on the previous cycle
        check("irq_match_at_max", 19'(timer_irq), 19'h1);
        cpu_read("status_read_set", 19'h40002, 19'h00001);
        cpu_write(19'h40002, 19'h00001);
        check("irq_cleared", 19'(timer_irq), 19'h0);
        cpu_read("status_read_clr", 19'h40002, 19'h00000);

        // ---------------- CMP match ----------------
        cpu_write(19'h40001, 19'h00005);
        cpu_read("cmp_written", 19'h40001, 19'h00005);
        cpu_write(19'h40000, 19'h00000);
        cpu_read("timer_zero", 19'h40000, 19'h00000);
        repeat (5) tick();
        cpu_read("timer_at_5", 19'h40000, 19'h00005);
        check("irq_not_yet", 19'(timer_irq), 19'h0);
        tick();
        check("irq_after_match", 19'(timer_irq), 19'h1);

        // Clear, then collide a clear with a fresh match
        cpu_write(19'h40002, 19'h00001);
        check("irq_cleared2", 19'(timer_irq), 19'h0);
        cpu_write(19'h40000, 19'h00003);
        tick();
        cpu_read("timer_at_4", 19'h40000, 19'h00004);
        tick();
        cpu_read("timer_at_5b", 19'h40000, 19'h00005);
        cpu_write(19'h40002, 19'h00001);
        check("irq_set_wins", 19'(timer_irq), 19'h1);

        // ---------------- LED ----------------
        cpu_write(19'h40003, 19'h12345);
        check("led_value", 19'(led), 19'h00045);
        cpu_read("led_read", 19'h40003, 19'h00045);

        // ---------------- reset mid-RUN ----------------
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rerst_cpu_hold",   19'(cpu_hold),   19'h1);
        check("rerst_load_ready", 19'(load_ready), 19'h1);
        check("rerst_led",        19'(led),        19'h0);
        check("rerst_irq",        19'(timer_irq),  19'h0);
        cpu_read("rerst_cmp", 19'h40001, 19'h7FFFF);
        cpu_write(19'h00010, 19'h11111);
        cpu_read("boot_store_ignored", 19'h00010, 19'h5A5A5);
        cpu_read("boot_timer_frozen", 19'h40000, 19'h00000);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("rerun_cpu_hold", 19'(cpu_hold), 19'h0);
        cpu_read("dmem_survives_reset", 19'h00010, 19'h5A5A5);
        pc = 19'd2;
        #1;
        check("imem_survives_reset", instr, 19'h00033);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cpu_mem_responder
`default_nettype wire
